// File: rtl/id_alu_decode.sv
// id_alu_decode: MIPS decode stage feeding the ALU.
// Takes one instruction plus its register-file read data over a valid/ready
// handshake and holds the decoded result in a single-entry output register
// that the execute stage drains with its own valid/ready handshake.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake (fetch)
//   inst                    instruction word
//   rs_addr/rt_addr         combinational regfile read addresses
//   rs_value/rt_value       same-cycle regfile read data
//   out_valid/out_ready     downstream handshake (execute)
//   alu_control             one-hot ALU op: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui (bit 11..0)
//   alu_src1/alu_src2       ALU operands (src1 = shift amount for shifts)
//   store_data              registered rt_value for stores
//   dest/reg_we             writeback register and enable
//   mem_read/mem_write      load / store flags
//   inst_invalid            unsupported encoding
//   decoded_cnt             number of accepted instructions (wraps)
module id_alu_decode #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [DATA_W-1:0] store_data,
    output logic [4:0]        dest,
    output logic              reg_we,
    output logic              mem_read,
    output logic              mem_write,
    output logic              inst_invalid,
    output logic [CNT_W-1:0]  decoded_cnt
);

    typedef enum logic [11:0] {
        ALU_NONE = 12'h000,
        ALU_ADD  = 12'h800,
        ALU_SUB  = 12'h400,
        ALU_SLT  = 12'h200,
        ALU_SLTU = 12'h100,
        ALU_AND  = 12'h080,
        ALU_NOR  = 12'h040,
        ALU_OR   = 12'h020,
        ALU_XOR  = 12'h010,
        ALU_SLL  = 12'h008,
        ALU_SRL  = 12'h004,
        ALU_SRA  = 12'h002,
        ALU_LUI  = 12'h001
    } alu_op_e;

    logic [5:0]        op, funct;
    logic [4:0]        rd, sa;
    logic [15:0]       imm;
    logic [DATA_W-1:0] sext, zext, sa_ext, rs_sh;

    assign op      = inst[31:26];
    assign rs_addr = inst[25:21];
    assign rt_addr = inst[20:16];
    assign rd      = inst[15:11];
    assign sa      = inst[10:6];
    assign funct   = inst[5:0];
    assign imm     = inst[15:0];
    assign sext    = {{(DATA_W-16){imm[15]}}, imm};
    assign zext    = {{(DATA_W-16){1'b0}}, imm};
    assign sa_ext  = {{(DATA_W-5){1'b0}}, sa};
    assign rs_sh   = {{(DATA_W-5){1'b0}}, rs_value[4:0]};

    alu_op_e           d_alu;
    logic [DATA_W-1:0] d_src1, d_src2;
    logic [4:0]        d_dest;
    logic              d_we, d_mr, d_mw, d_inv;

    always_comb begin
        d_alu  = ALU_NONE;
        d_src1 = rs_value;
        d_src2 = rt_value;
        d_dest = '0;
        d_we   = 1'b0;
        d_mr   = 1'b0;
        d_mw   = 1'b0;
        d_inv  = 1'b0;
        case (op)
            6'h00: begin
                d_dest = rd;
                d_we   = 1'b1;
                case (funct)
                    6'h20, 6'h21: d_alu = ALU_ADD;
                    6'h22, 6'h23: d_alu = ALU_SUB;
                    6'h24:        d_alu = ALU_AND;
                    6'h25:        d_alu = ALU_OR;
                    6'h26:        d_alu = ALU_XOR;
                    6'h27:        d_alu = ALU_NOR;
                    6'h2A:        d_alu = ALU_SLT;
                    6'h2B:        d_alu = ALU_SLTU;
                    6'h00: begin d_alu = ALU_SLL; d_src1 = sa_ext; end
                    6'h02: begin d_alu = ALU_SRL; d_src1 = sa_ext; end
                    6'h03: begin d_alu = ALU_SRA; d_src1 = sa_ext; end
                    6'h04: begin d_alu = ALU_SLL; d_src1 = rs_sh;  end
                    6'h06: begin d_alu = ALU_SRL; d_src1 = rs_sh;  end
                    6'h07: begin d_alu = ALU_SRA; d_src1 = rs_sh;  end
                    default:      d_inv = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin d_alu = ALU_ADD;  d_src2 = sext; d_dest = rt_addr; d_we = 1'b1; end
            6'h0A:        begin d_alu = ALU_SLT;  d_src2 = sext; d_dest = rt_addr; d_we = 1'b1; end
            6'h0B:        begin d_alu = ALU_SLTU; d_src2 = sext; d_dest = rt_addr; d_we = 1'b1; end
            6'h0C:        begin d_alu = ALU_AND;  d_src2 = zext; d_dest = rt_addr; d_we = 1'b1; end
            6'h0D:        begin d_alu = ALU_OR;   d_src2 = zext; d_dest = rt_addr; d_we = 1'b1; end
            6'h0E:        begin d_alu = ALU_XOR;  d_src2 = zext; d_dest = rt_addr; d_we = 1'b1; end
            6'h0F: begin
                d_alu  = ALU_LUI;
                d_src1 = '0;
                d_src2 = zext;
                d_dest = rt_addr;
                d_we   = 1'b1;
            end
            6'h23: begin d_alu = ALU_ADD; d_src2 = sext; d_dest = rt_addr; d_we = 1'b1; d_mr = 1'b1; end
            6'h2B: begin d_alu = ALU_ADD; d_src2 = sext; d_mw = 1'b1; end
            default: d_inv = 1'b1;
        endcase

        // Unsupported encodings are squashed to a harmless no-op entry.
        if (d_inv) begin
            d_alu  = ALU_NONE;
            d_src1 = '0;
            d_src2 = '0;
            d_dest = '0;
            d_we   = 1'b0;
            d_mr   = 1'b0;
            d_mw   = 1'b0;
        end
        // $0 is hard-wired; never request a write to it.
        if (d_dest == 5'd0) d_we = 1'b0;
    end

    logic accept;
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid    <= 1'b0;
            alu_control  <= '0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            store_data   <= '0;
            dest         <= '0;
            reg_we       <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            inst_invalid <= 1'b0;
            decoded_cnt  <= '0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            alu_control  <= d_alu;
            alu_src1     <= d_src1;
            alu_src2     <= d_src2;
            store_data   <= rt_value;
            dest         <= d_dest;
            reg_we       <= d_we;
            mem_read     <= d_mr;
            mem_write    <= d_mw;
            inst_invalid <= d_inv;
            decoded_cnt  <= decoded_cnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_alu_decode.sv
module tb_id_alu_decode;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_value, rt_value;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] alu_control;
    logic [31:0] alu_src1, alu_src2, store_data;
    logic [4:0]  dest;
    logic        reg_we, mem_read, mem_write, inst_invalid;
    logic [31:0] decoded_cnt;

    id_alu_decode #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_value(rs_value), .rt_value(rt_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .store_data(store_data), .dest(dest), .reg_we(reg_we),
        .mem_read(mem_read), .mem_write(mem_write),
        .inst_invalid(inst_invalid), .decoded_cnt(decoded_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the expected contents of the output register.
    typedef struct {
        logic [11:0] alu;
        logic [31:0] s1, s2;
        logic [4:0]  dest;
        logic        we, mr, mw, inv;
    } dec_t;

    logic        m_valid;
    dec_t        m_dec;
    logic [31:0] m_sd;
    logic [31:0] m_cnt;

    string alu_names [12] = '{"add","sub","slt","sltu","and","nor","or","xor","sll","srl","sra","lui"};
    logic [5:0] valid_ops   [13] = '{6'h00,6'h00,6'h00,6'h08,6'h09,6'h0A,6'h0B,6'h0C,6'h0D,6'h0E,6'h0F,6'h23,6'h2B};
    logic [5:0] valid_functs[16] = '{6'h20,6'h21,6'h22,6'h23,6'h24,6'h25,6'h26,6'h27,6'h2A,6'h2B,6'h00,6'h02,6'h03,6'h04,6'h06,6'h07};

    function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] rsv, input logic [31:0] rtv);
        dec_t d;
        string nm = "";
        string how = "";
        int unsigned op  = w[31:26];
        int unsigned fn  = w[5:0];
        int unsigned rs  = w[25:21];
        int unsigned rt  = w[20:16];
        int unsigned rd  = w[15:11];
        int unsigned sa  = w[10:6];
        int unsigned imm = w[15:0];
        logic [31:0] simm = (imm >= 32768) ? 32'(imm + 32'hFFFF0000) : 32'(imm);
        d = '{alu: 12'h0, s1: 32'h0, s2: 32'h0, dest: 5'h0, we: 1'b0, mr: 1'b0, mw: 1'b0, inv: 1'b0};
        if (op == 0) begin
            case (fn)
                'h20, 'h21: nm = "add";
                'h22, 'h23: nm = "sub";
                'h24: nm = "and";  'h25: nm = "or";  'h26: nm = "xor"; 'h27: nm = "nor";
                'h2A: nm = "slt";  'h2B: nm = "sltu";
                'h00: nm = "sll";  'h02: nm = "srl"; 'h03: nm = "sra";
                'h04: nm = "sll";  'h06: nm = "srl"; 'h07: nm = "sra";
                default: nm = "";
            endcase
            how = (fn < 4) ? "shamt" : (fn < 8) ? "shvar" : "reg";
        end else begin
            case (op)
                'h08, 'h09: begin nm = "add";  how = "sext"; end
                'h0A:       begin nm = "slt";  how = "sext"; end
                'h0B:       begin nm = "sltu"; how = "sext"; end
                'h0C:       begin nm = "and";  how = "zext"; end
                'h0D:       begin nm = "or";   how = "zext"; end
                'h0E:       begin nm = "xor";  how = "zext"; end
                'h0F:       begin nm = "lui";  how = "lui";  end
                'h23:       begin nm = "add";  how = "load"; end
                'h2B:       begin nm = "add";  how = "store"; end
                default:    nm = "";
            endcase
        end
        if (nm == "") begin
            d.inv = 1'b1;
            return d;
        end
        for (int i = 0; i < 12; i++)
            if (alu_names[i] == nm) d.alu[11-i] = 1'b1;
        d.s1 = rsv;
        d.s2 = rtv;
        d.dest = 5'(rt);
        case (how)
            "reg":   d.dest = 5'(rd);
            "shamt": begin d.dest = 5'(rd); d.s1 = sa; end
            "shvar": begin d.dest = 5'(rd); d.s1 = rsv % 32; end
            "sext":  d.s2 = simm;
            "zext":  d.s2 = imm;
            "lui":   begin d.s1 = 0; d.s2 = imm; end
            "load":  begin d.s2 = simm; d.mr = 1'b1; end
            "store": begin d.s2 = simm; d.mw = 1'b1; d.dest = 0; end
            default: ;
        endcase
        d.we = (how != "store") && (d.dest != 0);
        if (rs > 31) d.inv = 1'b1;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid",    32'(out_valid),    32'(m_valid));
        chk("alu_control",  32'(alu_control),  32'(m_dec.alu));
        chk("alu_src1",     alu_src1,          m_dec.s1);
        chk("alu_src2",     alu_src2,          m_dec.s2);
        chk("store_data",   store_data,        m_sd);
        chk("dest",         32'(dest),         32'(m_dec.dest));
        chk("reg_we",       32'(reg_we),       32'(m_dec.we));
        chk("mem_read",     32'(mem_read),     32'(m_dec.mr));
        chk("mem_write",    32'(mem_write),    32'(m_dec.mw));
        chk("inst_invalid", 32'(inst_invalid), 32'(m_dec.inv));
        chk("decoded_cnt",  decoded_cnt,       m_cnt);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_dec   = '{alu: 12'h0, s1: 32'h0, s2: 32'h0, dest: 5'h0, we: 1'b0, mr: 1'b0, mw: 1'b0, inv: 1'b0};
        m_sd    = 32'h0;
        m_cnt   = 32'h0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] rsv,
                        input logic [31:0] rtv, input logic ordy);
        logic exp_rdy;
        in_valid = v; inst = w; rs_value = rsv; rt_value = rtv; out_ready = ordy;
        #1;
        exp_rdy = !m_valid || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("rs_addr",  32'(rs_addr),  (w >> 21) & 32'h1F);
        chk("rt_addr",  32'(rt_addr),  (w >> 16) & 32'h1F);
        @(posedge clk);
        if (v && exp_rdy) begin
            m_dec   = ref_decode(w, rsv, rtv);
            m_sd    = rtv;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            w[31:26] = valid_ops[$urandom_range(0, 12)];
            if (w[31:26] == 6'h00) w[5:0] = valid_functs[$urandom_range(0, 15)];
        end
        return w;
    endfunction

    initial begin
        model_reset();
        resetn = 1'b0; in_valid = 1'b0; inst = '0; rs_value = '0; rt_value = '0; out_ready = 1'b0;
        #7;
        check_outputs();
        @(posedge clk); #1;
        resetn = 1'b1;

        // addu $3,$1,$2
        step(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b1);
        chk("addu_alu",  32'(alu_control), 32'h800);
        chk("addu_src1", alu_src1, 32'd5);
        chk("addu_src2", alu_src2, 32'd7);
        chk("addu_dest", 32'(dest), 32'd3);
        chk("addu_cnt",  decoded_cnt, 32'd1);
        // sra $4,$2,3
        step(1'b1, 32'h000220C3, 32'h12345678, 32'h80000000, 1'b1);
        chk("sra_alu",  32'(alu_control), 32'h002);
        chk("sra_src1", alu_src1, 32'd3);
        chk("sra_src2", alu_src2, 32'h80000000);
        // andi $5,$1,0xFFFF
        step(1'b1, 32'h3025FFFF, 32'hDEADBEEF, 32'h1, 1'b1);
        chk("andi_alu",  32'(alu_control), 32'h080);
        chk("andi_src2", alu_src2, 32'h0000FFFF);
        // lw $6,-4($1)
        step(1'b1, 32'h8C26FFFC, 32'h100, 32'h2, 1'b1);
        chk("lw_alu",  32'(alu_control), 32'h800);
        chk("lw_src2", alu_src2, 32'hFFFFFFFC);
        chk("lw_mr",   32'(mem_read), 32'd1);
        // stall for 3 cycles with a new instruction waiting (or $7,$1,$2)
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00223825, 32'hF0, 32'h0F, 1'b0);
            chk("stall_rdy", 32'(in_ready), 32'd0);
            chk("stall_dest", 32'(dest), 32'd6);
        end
        step(1'b1, 32'h00223825, 32'hF0, 32'h0F, 1'b1);
        chk("refill_alu", 32'(alu_control), 32'h020);
        chk("refill_cnt", decoded_cnt, 32'd5);
        // unsupported encoding still flows and is counted
        step(1'b1, 32'hFC000000, 32'h55, 32'h66, 1'b1);
        chk("inv_flag", 32'(inst_invalid), 32'd1);
        chk("inv_alu",  32'(alu_control), 32'h000);
        chk("inv_we",   32'(reg_we), 32'd0);
        chk("inv_cnt",  decoded_cnt, 32'd6);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rv1 = $urandom;
            logic [31:0] rv2 = $urandom;
            step(1'($urandom_range(0, 3) != 0), rand_inst(), rv1, rv2,
                 1'($urandom_range(0, 3) != 0));
        end

        // asynchronous reset while holding a stalled entry
        step(1'b1, 32'h00221821, 32'd9, 32'd9, 1'b1);
        step(1'b1, 32'h3C0A1234, 32'd0, 32'd0, 1'b0);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_cnt",   decoded_cnt, 32'd0);
        check_outputs();
        @(posedge clk); #1;
        resetn = 1'b1;
        step(1'b1, 32'h3C0A1234, 32'd0, 32'd0, 1'b1);
        chk("lui_alu", 32'(alu_control), 32'h001);
        chk("lui_cnt", decoded_cnt, 32'd1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_alu_decode.md
Name: id_alu_decode

Overview:
- Decode stage of the multi-cycle CPU, directly upstream of the ALU.
- Accepts one fetched MIPS instruction plus its register-file read data over a valid/ready handshake.
- Produces the ALU's 12-bit one-hot control word, both ALU operands, and writeback/memory side-band controls.
- Holds the result in a single-entry output register that the execute stage drains with its own valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width of operands, register data and immediates after extension
- CNT_W, 32, width of the decoded-instruction counter

Ports:
- clk  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept this cycle
- inst  input  32  instruction word
- rs_addr  output  5  regfile read address 1 = inst[25:21], combinational
- rt_addr  output  5  regfile read address 2 = inst[20:16], combinational
- rs_value  input  DATA_W  regfile data for rs_addr, same cycle (asynchronous read)
- rt_value  input  DATA_W  regfile data for rt_addr, same cycle
- out_valid  output  1  output register holds a decoded instruction
- out_ready  input  1  execute stage consumes this cycle
- alu_control  output  12  one-hot; bit 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
- alu_src1  output  DATA_W  ALU operand 1 (shift amount for shifts)
- alu_src2  output  DATA_W  ALU operand 2 (value shifted for shifts)
- store_data  output  DATA_W  rt_value, registered, for sw
- dest  output  5  writeback register
- reg_we  output  1  writeback enable
- mem_read  output  1  load
- mem_write  output  1  store
- inst_invalid  output  1  unsupported encoding
- decoded_cnt  output  CNT_W  count of accepted instructions

Behaviour:
- Reset: out_valid=0, alu_control=0, alu_src1=alu_src2=store_data=0, dest=0, reg_we=mem_read=mem_write=inst_invalid=0, decoded_cnt=0. Reset asserted mid-transfer discards the held entry; no partial outputs.
- in_ready = ~out_valid | out_ready (combinational; a full register drains and refills in the same cycle).
- Accept when in_valid & in_ready: all outputs load the decode of inst/rs_value/rt_value on that edge; out_valid=1; decoded_cnt += 1 with wrap at 2^CNT_W.
- Drain: if out_valid & out_ready and no accept, out_valid=0; data outputs hold their last value.
- Stall: out_valid & ~out_ready keeps every output stable; in_ready=0.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle with out_ready held high.
- Fields: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0], imm=[15:0]; sext = sign-extended imm, zext = zero-extended imm.
- R-type (op=0), dest=rd, reg_we=1, src1=rs_value, src2=rt_value unless noted:
  - add/addu 0x20/0x21 -> add
  - sub/subu 0x22/0x23 -> sub
  - and 0x24, or 0x25, xor 0x26, nor 0x27
  - slt 0x2A, sltu 0x2B
  - sll/srl/sra 0x00/0x02/0x03: src1={27'b0,sa}, src2=rt_value
  - sllv/srlv/srav 0x04/0x06/0x07: src1={27'b0,rs_value[4:0]}, src2=rt_value
- I-type, dest=rt, reg_we=1, src1=rs_value:
  - addi/addiu 0x08/0x09 -> add, src2=sext
  - slti 0x0A -> slt, src2=sext
  - sltiu 0x0B -> sltu, src2=sext
  - andi 0x0C, ori 0x0D, xori 0x0E -> src2=zext
  - lui 0x0F -> lui, src1=0, src2=zext
- Memory:
  - lw 0x23 -> add, src2=sext, dest=rt, reg_we=1, mem_read=1
  - sw 0x2B -> add, src2=sext, dest=0, reg_we=0, mem_write=1
- Any other op/funct: inst_invalid=1, alu_control=0, reg_we=mem_read=mem_write=0, src1=src2=0. The entry still flows through the handshake and is counted.
- Any write with dest=0 forces reg_we=0.
- alu_control is exactly one-hot for every valid instruction.

Test Plan:
- Reset then accept 0x00221821 (addu $3,$1,$2), rs_value=5, rt_value=7 -> next cycle out_valid=1, alu_control=0x800, src1=5, src2=7, dest=3, reg_we=1, decoded_cnt=1.
- 0x000220C3 (sra $4,$2,3), rt_value=0x80000000 -> alu_control=0x002, src1=3, src2=0x80000000, dest=4.
- 0x3025FFFF (andi $5,$1,0xFFFF) -> alu_control=0x080, src2=0x0000FFFF, dest=5; 0x8C26FFFC (lw $6,-4($1)) -> alu_control=0x800, src2=0xFFFFFFFC, mem_read=1, dest=6.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> drain and accept on the same edge, second instruction appears next cycle, no gap or duplicate.
- 0xFC000000 -> inst_invalid=1, alu_control=0, reg_we=0, decoded_cnt increments.
- resetn low while out_valid=1 and stalled -> out_valid=0 and decoded_cnt=0 immediately, without waiting for a clock edge.
